// File: rtl/xor_sched_pkg.sv
// Shared types and helpers for the xor_sched slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xor_sched_pkg;

    // Operand width of the xor_m datapath.
    localparam int XW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Winner index of a circular scan starting at ptr+1.
    // req is zero-padded to 8 bits so one function covers NREQ up to 8.
    // Offsets are walked from the far end towards ptr+1, so the nearest
    // set bit is the last one written and therefore wins.
    // Returns ptr unchanged when no bit is set; callers gate on |req.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input logic [3:0] nreq);
        logic [2:0] win;
        int         s;
        win = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (k <= int'(nreq)) begin
                s = int'(ptr) + k;
                if (s >= int'(nreq)) begin
                    s = s - int'(nreq);
                end
                if (req[s[2:0]]) begin
                    win = s[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/xor_m.sv
// 4-bit XOR datapath shared by the scheduler.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; y = a ^ b.
module xor_m (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant plus last-winner pointer.
// Latency: grant is combinational from req/en; pointer updates on the grant edge.
// Backpressure: en low suppresses the grant and freezes the pointer.
// Ports: req (per requester), en (issue permitted), gnt (one-hot),
//        gnt_idx (winner index), gnt_any (a grant is issued this cycle).
module rr_arb
    import xor_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr;
    logic [2:0]     pick;

    always_comb begin
        pick    = rr_pick(8'(req), 3'(ptr), 4'(NREQ));
        gnt_idx = pick[IDW-1:0];
        // Gating with rst_n keeps gnt low for the whole reset window,
        // not just from the first edge after it.
        gnt_any = en && (|req) && rst_n;
        gnt     = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Reset to the last index so requester 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDW'(NREQ - 1);
        end else if (gnt_any) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/xor_sched.sv
// Shares one xor_m between NREQ requesters; returns y tagged with requester id.
// Latency: 1 cycle from gnt[i] to rsp_valid carrying that result; 1 result/cycle.
// Backpressure: while a result is held and rsp_ready is low, no grant is issued.
// Ports: req/a_in/b_in per requester (4 bits each, requester i at [4i+3:4i]),
//        gnt one-hot, rsp_valid/rsp_ready handshake, rsp_y result, rsp_id source.
// Build option XOR_SCHED_PARITY_EN adds rsp_par = ^rsp_y, registered with it.
module xor_sched
    import xor_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*4-1:0] a_in,
    input  logic [NREQ*4-1:0] b_in,
    output logic [NREQ-1:0]  gnt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XW-1:0]    rsp_y,
`ifdef XOR_SCHED_PARITY_EN
    output logic             rsp_par,
`endif
    output logic [IDW-1:0]   rsp_id
);

    state_t         state, state_nxt;
    logic           can_issue;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [XW-1:0]  a_sel, b_sel, y;

    // A held result can be replaced in the same cycle it is consumed.
    assign can_issue = (state == IDLE) || rsp_ready;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .en      (can_issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        a_sel = a_in[int'(gnt_idx)*XW +: XW];
        b_sel = b_in[int'(gnt_idx)*XW +: XW];
    end

    xor_m u_xor (
        .a (a_sel),
        .b (b_sel),
        .y (y)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_any) state_nxt = HOLD;
            HOLD: if (rsp_ready) state_nxt = gnt_any ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign rsp_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y  <= '0;
            rsp_id <= '0;
        end else if (gnt_any) begin
            rsp_y  <= y;
            rsp_id <= gnt_idx;
        end
    end

`ifdef XOR_SCHED_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_par <= 1'b0;
        end else if (gnt_any) begin
            rsp_par <= ^y;
        end
    end
`endif

endmodule

// File: tb/tb_xor_sched.sv
module tb_xor_sched;

    localparam int NREQ = 4;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ*4-1:0] a_in;
    logic [NREQ*4-1:0] b_in;
    logic [NREQ-1:0]  gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_y;
    logic [1:0]       rsp_id;
`ifdef XOR_SCHED_PARITY_EN
    logic             rsp_par;
`endif

    int checks;
    int failures;

    // Reference state: who was granted last, and what result is outstanding.
    int       m_last;
    bit       m_valid;
    int       m_y;
    int       m_id;

    logic [NREQ-1:0] seen_gnt [0:4];
    logic [3:0]      seen_y   [0:3];
    logic [1:0]      seen_id  [0:4];
    logic [3:0]      y_hold;

    xor_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
`ifdef XOR_SCHED_PARITY_EN
        .rsp_par   (rsp_par),
`endif
        .rsp_id    (rsp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_last  = NREQ - 1;
        m_valid = 1'b0;
        m_y     = 0;
        m_id    = 0;
    endfunction

    // Which requester should win now, or -1 for no grant.
    function automatic int model_winner();
        if (m_valid && !rsp_ready) return -1;
        for (int off = 1; off <= NREQ; off++) begin
            int i;
            i = (m_last + off) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    // One clock: inputs already applied at the falling edge; check, then advance.
    task automatic step();
        int w;
        int exp_gnt;
        #1;
        w = model_winner();
        exp_gnt = (w < 0) ? 0 : (1 << w);
        chk("gnt", int'(gnt), exp_gnt);
        chk("rsp_valid", int'(rsp_valid), int'(m_valid));
        if (m_valid) begin
            chk("rsp_y", int'(rsp_y), m_y);
            chk("rsp_id", int'(rsp_id), m_id);
`ifdef XOR_SCHED_PARITY_EN
            chk("rsp_par", int'(rsp_par), ($countones(m_y) % 2));
`endif
        end
        @(posedge clk);
        if (w >= 0) begin
            m_valid = 1'b1;
            m_y     = ((a_in >> (4*w)) & 15) ^ ((b_in >> (4*w)) & 15);
            m_id    = w;
            m_last  = w;
        end else if (!m_valid || rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // Reset values.
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_y", int'(rsp_y), 0);
        chk("reset_id", int'(rsp_id), 0);
        req = 4'b1111;
        #1;
        chk("reset_gnt", int'(gnt), 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester.
        req = 4'b0001; a_in = 16'h0008; b_in = 16'h0000;
        #1 chk("single_gnt", int'(gnt), 4'b0001);
        step();
        req = '0;
        #1 chk("single_valid", int'(rsp_valid), 1);
        chk("single_y", int'(rsp_y), 4'b1000);
        chk("single_id", int'(rsp_id), 0);
        step();
        #1 chk("single_drain", int'(rsp_valid), 0);
        step();

        // Full contention from a fresh pointer.
        do_reset();
        req  = 4'b1111;
        a_in = {4'd3, 4'd2, 4'd1, 4'd0};
        b_in = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            #1;
            seen_gnt[c] = gnt;
            if (c > 0) seen_y[c-1] = rsp_y;
            if (c > 0) seen_id[c-1] = rsp_id;
            step();
        end
        #1 seen_id[4] = rsp_id;
        chk("rr_gnt0", int'(seen_gnt[0]), 4'b0001);
        chk("rr_gnt1", int'(seen_gnt[1]), 4'b0010);
        chk("rr_gnt2", int'(seen_gnt[2]), 4'b0100);
        chk("rr_gnt3", int'(seen_gnt[3]), 4'b1000);
        chk("rr_gnt4", int'(seen_gnt[4]), 4'b0001);
        chk("rr_y0", int'(seen_y[0]), 4'b1111);
        chk("rr_y1", int'(seen_y[1]), 4'b1110);
        chk("rr_y2", int'(seen_y[2]), 4'b1101);
        chk("rr_y3", int'(seen_y[3]), 4'b1100);
        chk("rr_id3", int'(seen_id[3]), 3);
        chk("rr_id4", int'(seen_id[4]), 0);

        // Equal operands on requester 2.
        req  = 4'b0100;
        a_in = 16'h0300;
        b_in = 16'h0300;
        step();
        req = '0;
        #1 chk("eq_y", int'(rsp_y), 0);
        chk("eq_id", int'(rsp_id), 2);
`ifdef XOR_SCHED_PARITY_EN
        chk("eq_par", int'(rsp_par), 0);
`endif
        step();
        step();

        // Backpressure: pointer sits at 2, so requester 1 wins first, then 2.
        req  = 4'b0110;
        a_in = 16'h0A50;
        b_in = 16'h0C30;
        #1 chk("bp_first_gnt", int'(gnt), 4'b0010);
        step();
        rsp_ready = 1'b0;
        #1 y_hold = rsp_y;
        chk("bp_hold_y", int'(y_hold), 4'b0110);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_stall_gnt", int'(gnt), 0);
            chk("bp_stable_y", int'(rsp_y), int'(y_hold));
            chk("bp_stable_id", int'(rsp_id), 1);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_resume_gnt", int'(gnt), 4'b0100);
        step();
        #1 chk("bp_next_gnt", int'(gnt), 4'b0010);
        step();
        req = '0;
        step();
        step();

        // Reset while a result is held.
        req  = 4'b1000;
        a_in = 16'h5000;
        b_in = 16'h0000;
        step();
        req = 4'b1111;
        #1 chk("mid_valid_before", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", int'(rsp_valid), 0);
        chk("mid_y", int'(rsp_y), 0);
        chk("mid_id", int'(rsp_id), 0);
        chk("mid_gnt", int'(gnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_in = 16'h0007;
        b_in = 16'h0000;
        #1 chk("post_reset_gnt", int'(gnt), 4'b0001);
        step();
        req = 4'b0000;
        // Parity vector: 0111 ^ 0000.
        #1 chk("par_y", int'(rsp_y), 4'b0111);
`ifdef XOR_SCHED_PARITY_EN
        chk("par_bit", int'(rsp_par), 1);
`endif
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
